// File: rtl/mem_bus_arbiter.sv
// Arbiter between the instruction-fetch port and the data-memory port for the shared bus.
// Data wins simultaneous requests unless it won the previous grant; every bus access is
// bounded by a timeout that completes the access with a poison word and a sticky error.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  // Instruction-fetch port
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_valid_o,
  output logic        if_stall_o,
  // Data-memory port
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  input  logic [2:0]  dm_funct3_i,
  output logic [31:0] dm_rdata_o,
  output logic        dm_valid_o,
  output logic        dm_stall_o,
  // Shared bus
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [2:0]  bus_size_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic        timeout_err_o
);

  typedef enum logic [1:0] {StIdle, StGntIf, StGntDm} state_e;

  localparam logic [31:0] TimeoutData = 32'hDEADBEEF;
  localparam logic [2:0]  FetchSize   = 3'b010;
  localparam logic [7:0]  CntLast     = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic        last_gnt_dm_q, last_gnt_dm_d;  // 0 = IF granted last, 1 = DM
  logic [7:0]  cnt_q, cnt_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [2:0]  bus_size_q, bus_size_d;
  logic        err_q, err_d;

  logic        granted;
  logic        ack_done;
  logic        to_done;
  logic        done;
  logic [31:0] done_rdata;

  // Completion decode: an ack always beats a coincident timeout.
  always_comb begin
    granted    = (state_q != StIdle);
    ack_done   = granted && bus_ack_i;
    to_done    = granted && !bus_ack_i && (cnt_q == CntLast);
    done       = ack_done || to_done;
    done_rdata = bus_ack_i ? bus_rdata_i : TimeoutData;
  end

  // Next-state: arbitration in idle, completion/timeout counting while granted.
  always_comb begin
    state_d       = state_q;
    last_gnt_dm_d = last_gnt_dm_q;
    cnt_d         = cnt_q;
    bus_we_d      = bus_we_q;
    bus_addr_d    = bus_addr_q;
    bus_wdata_d   = bus_wdata_q;
    bus_size_d    = bus_size_q;
    err_d         = err_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (dm_req_i && (!if_req_i || !last_gnt_dm_q)) begin
          state_d       = StGntDm;
          last_gnt_dm_d = 1'b1;
          bus_we_d      = dm_we_i;
          bus_addr_d    = dm_addr_i;
          bus_wdata_d   = dm_wdata_i;
          bus_size_d    = dm_funct3_i;
        end else if (if_req_i) begin
          state_d       = StGntIf;
          last_gnt_dm_d = 1'b0;
          bus_we_d      = 1'b0;
          bus_addr_d    = if_addr_i;
          bus_wdata_d   = '0;
          bus_size_d    = FetchSize;
        end
      end
      StGntIf, StGntDm: begin
        if (done) begin
          state_d     = StIdle;
          cnt_d       = '0;
          bus_we_d    = 1'b0;
          bus_addr_d  = '0;
          bus_wdata_d = '0;
          bus_size_d  = '0;
          if (to_done) err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and bus-side registers; reset aborts any transaction in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      last_gnt_dm_q <= 1'b0;
      cnt_q         <= '0;
      bus_we_q      <= 1'b0;
      bus_addr_q    <= '0;
      bus_wdata_q   <= '0;
      bus_size_q    <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_gnt_dm_q <= last_gnt_dm_d;
      cnt_q         <= cnt_d;
      bus_we_q      <= bus_we_d;
      bus_addr_q    <= bus_addr_d;
      bus_wdata_q   <= bus_wdata_d;
      bus_size_q    <= bus_size_d;
      err_q         <= err_d;
    end
  end

  // Port-side outputs: valid and rdata in the completion cycle, stall until then.
  always_comb begin
    bus_req_o     = granted;
    bus_we_o      = bus_we_q;
    bus_addr_o    = bus_addr_q;
    bus_wdata_o   = bus_wdata_q;
    bus_size_o    = bus_size_q;
    timeout_err_o = err_q;
    if_valid_o    = (state_q == StGntIf) && done;
    dm_valid_o    = (state_q == StGntDm) && done;
    if_rdata_o    = if_valid_o ? done_rdata : '0;
    dm_rdata_o    = dm_valid_o ? done_rdata : '0;
    if_stall_o    = if_req_i && !if_valid_o;
    dm_stall_o    = dm_req_i && !dm_valid_o;
  end

endmodule
